// File: rtl/complex_accumulator.sv
// complex_accumulator
// Reduction stage of the VMM datapath: sums LEN consecutive complex samples
// into ACC_W-bit accumulators and presents one complex result per vector,
// with valid/ready handshakes on both sides.
//
// Build option:
//   COMPLEX_ACC_SAT_EN  defined   -> a lane that overflows saturates to the
//                                    ACC_W-bit signed limit, later terms
//                                    continue from the saturated value.
//                       undefined -> lanes wrap modulo 2^ACC_W.
//   out_ovf is reported in both builds.
//
// state | meaning
// ------+------------------------------------------------------------------
// ACCUM | accepting samples, in_ready=1, accumulating into acc_real/acc_imag
// HOLD  | result presented on out_*, in_ready=0, waiting for out_ready
module complex_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8,
    parameter int CNT_W  = $clog2(LEN + 1)
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_real,
    input  logic [DATA_W-1:0]   in_imag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_real,
    output logic [ACC_W-1:0]    out_imag,
    output logic                out_ovf,
    output logic [CNT_W-1:0]    term_cnt
);

    // Catch illegal parameterisations at elaboration time.
    if (ACC_W < DATA_W) begin : g_bad_acc_w
        $error("complex_accumulator: ACC_W must be >= DATA_W");
    end
    if (LEN < 1) begin : g_bad_len
        $error("complex_accumulator: LEN must be >= 1");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ACC_W-1:0]   acc_real_q;
    logic [ACC_W-1:0]   acc_imag_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   term_cnt_q;
    logic [ACC_W-1:0]   out_real_q;
    logic [ACC_W-1:0]   out_imag_q;
    logic               out_ovf_q;

    logic               xfer;
    logic               done;
    logic [CNT_W-1:0]   cnt_next;
    logic               last_term;

    logic [ACC_W:0]     sum_real;
    logic [ACC_W:0]     sum_imag;
    logic               ovf_real;
    logic               ovf_imag;
    logic               ovf_now;
    logic [ACC_W-1:0]   real_next;
    logic [ACC_W-1:0]   imag_next;

    // One extra bit of headroom: the sign-extended accumulator plus the
    // sign-extended sample can never overflow ACC_W+1 bits.
    function automatic logic [ACC_W:0] lane_sum(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] x
    );
        logic [ACC_W:0] acc_ext;
        logic [ACC_W:0] x_ext;
        acc_ext = {acc[ACC_W-1], acc};
        x_ext   = {{(ACC_W + 1 - DATA_W){x[DATA_W-1]}}, x};
        return acc_ext + x_ext;
    endfunction

    // The ACC_W-bit result of a lane overflowed when the top two bits of
    // the widened sum disagree.
    function automatic logic lane_ovf(input logic [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    // Value the lane accumulator takes after this term: either the wrapped
    // low bits, or the signed limit in the direction of the true sum.
    function automatic logic [ACC_W-1:0] lane_next(input logic [ACC_W:0] s);
        logic [ACC_W-1:0] r;
        r = s[ACC_W-1:0];
`ifdef COMPLEX_ACC_SAT_EN
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                r = {1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end
`endif
        return r;
    endfunction

    // Lane arithmetic and handshake qualifiers.
    always_comb begin
        xfer      = in_valid & in_ready;
        done      = out_valid & out_ready;
        cnt_next  = term_cnt_q + CNT_W'(1);
        last_term = (cnt_next == CNT_W'(LEN));
        sum_real  = lane_sum(acc_real_q, in_real);
        sum_imag  = lane_sum(acc_imag_q, in_imag);
        ovf_real  = lane_ovf(sum_real);
        ovf_imag  = lane_ovf(sum_imag);
        ovf_now   = ovf_real | ovf_imag;
        real_next = lane_next(sum_real);
        imag_next = lane_next(sum_imag);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave ACCUM on the LEN-th transfer, leave HOLD on
    // the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: begin
                if (xfer && last_term) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (done) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Accumulators, term counter, sticky overflow and result registers.
    // The result registers are separate from the accumulators so that the
    // presented result stays put after the handshake until the next vector
    // completes.
    always_ff @(posedge CLK) begin
        if (rst) begin
            acc_real_q <= '0;
            acc_imag_q <= '0;
            sticky_q   <= 1'b0;
            term_cnt_q <= '0;
            out_real_q <= '0;
            out_imag_q <= '0;
            out_ovf_q  <= 1'b0;
        end else if (xfer) begin
            acc_real_q <= real_next;
            acc_imag_q <= imag_next;
            sticky_q   <= sticky_q | ovf_now;
            term_cnt_q <= cnt_next;
            if (last_term) begin
                out_real_q <= real_next;
                out_imag_q <= imag_next;
                out_ovf_q  <= sticky_q | ovf_now;
            end
        end else if (done) begin
            acc_real_q <= '0;
            acc_imag_q <= '0;
            sticky_q   <= 1'b0;
            term_cnt_q <= '0;
        end
    end

    assign out_real = out_real_q;
    assign out_imag = out_imag_q;
    assign out_ovf  = out_ovf_q;
    assign term_cnt = term_cnt_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Bench for complex_accumulator: default configuration driven from a vector
// table with a result scoreboard, plus hand-written sequences for HOLD stall,
// mid-vector reset, lane overflow (ACC_W=16, LEN=2) and LEN=1.
module tb_complex_accumulator;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    // Default configuration DUT (DATA_W=16, ACC_W=24, LEN=8)
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_ovf;
    logic [15:0] d_in_real, d_in_imag;
    logic [23:0] d_out_real, d_out_imag;
    logic [3:0]  d_term_cnt;

    // Overflow configuration DUT (DATA_W=16, ACC_W=16, LEN=2)
    logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_ovf;
    logic [15:0] o_in_real, o_in_imag;
    logic [15:0] o_out_real, o_out_imag;
    logic [1:0]  o_term_cnt;

    // Single-term configuration DUT (DATA_W=16, ACC_W=24, LEN=1)
    logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_ovf;
    logic [15:0] l_in_real, l_in_imag;
    logic [23:0] l_out_real, l_out_imag;
    logic [0:0]  l_term_cnt;

    complex_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(8)) u_dut (
        .CLK(CLK), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_real(d_in_real), .in_imag(d_in_imag),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_real(d_out_real), .out_imag(d_out_imag),
        .out_ovf(d_out_ovf), .term_cnt(d_term_cnt)
    );

    complex_accumulator #(.DATA_W(16), .ACC_W(16), .LEN(2)) u_ovf (
        .CLK(CLK), .rst(rst),
        .in_valid(o_in_valid), .in_ready(o_in_ready),
        .in_real(o_in_real), .in_imag(o_in_imag),
        .out_valid(o_out_valid), .out_ready(o_out_ready),
        .out_real(o_out_real), .out_imag(o_out_imag),
        .out_ovf(o_out_ovf), .term_cnt(o_term_cnt)
    );

    complex_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(1)) u_len1 (
        .CLK(CLK), .rst(rst),
        .in_valid(l_in_valid), .in_ready(l_in_ready),
        .in_real(l_in_real), .in_imag(l_in_imag),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .out_real(l_out_real), .out_imag(l_out_imag),
        .out_ovf(l_out_ovf), .term_cnt(l_term_cnt)
    );

`ifdef COMPLEX_ACC_SAT_EN
    localparam int OVF_POS_EXP = 32767;
    localparam int OVF_NEG_EXP = -32768;
`else
    localparam int OVF_POS_EXP = -32768;
    localparam int OVF_NEG_EXP = 32767;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int re;
        int im;
        int ovf;
    } result_t;

    result_t sb_q[$];

    typedef struct {
        int re0;
        int re_step;
        int im0;
        int im_step;
        int gap;
        int exp_re;
        int exp_im;
        int exp_ovf;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one sample on the default DUT; returns at the falling edge
    // after the sample was accepted, with in_valid still high.
    task automatic send(input int re, input int im);
        int n;
        d_in_valid = 1'b1;
        d_in_real  = 16'(re);
        d_in_imag  = 16'(im);
        n = 0;
        while (!d_in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            check("send_timeout", 1, 0);
        end
        @(negedge CLK);
    endtask

    // Two-term vector on the overflow DUT, checked when the result appears.
    task automatic o_vec(input int a, input int b, input int exp_re, input int exp_ovf);
        o_in_valid = 1'b1;
        o_in_real  = 16'(a);
        o_in_imag  = 16'(0);
        @(negedge CLK);
        o_in_real  = 16'(b);
        @(negedge CLK);
        o_in_valid = 1'b0;
        check("ovf_valid", longint'(o_out_valid), 1);
        check("ovf_flag", longint'(o_out_ovf), exp_ovf);
        check("ovf_real", longint'($signed(o_out_real)), exp_re);
        check("ovf_imag", longint'($signed(o_out_imag)), 0);
        @(negedge CLK);
    endtask

    // Single sample on the LEN=1 DUT; result must appear one cycle later.
    task automatic l_one(input int re, input int im);
        int n;
        l_in_valid = 1'b1;
        l_in_real  = 16'(re);
        l_in_imag  = 16'(im);
        n = 0;
        while (!l_in_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            check("len1_timeout", 1, 0);
        end
        @(negedge CLK);
        l_in_valid = 1'b0;
        check("len1_valid", longint'(l_out_valid), 1);
        check("len1_real", longint'($signed(l_out_real)), re);
        check("len1_imag", longint'($signed(l_out_imag)), im);
        check("len1_cnt", longint'(l_term_cnt), 1);
    endtask

    // Scoreboard: each completed handshake on the default DUT pops one
    // expected result.
    always @(negedge CLK) begin
        result_t e;
        #1;
        if (d_out_valid && d_out_ready && !rst) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_out: got (%0d,%0d) expected no result",
                         $signed(d_out_real), $signed(d_out_imag));
            end else begin
                e = sb_q.pop_front();
                check("sb_real", longint'($signed(d_out_real)), e.re);
                check("sb_imag", longint'($signed(d_out_imag)), e.im);
                check("sb_ovf", longint'(d_out_ovf), e.ovf);
            end
        end
    end

    initial begin
        tbl[0] = '{1, 1, -1, -1, 0, 36, -36, 0};
        tbl[1] = '{100, 0, -100, 0, 1, 800, -800, 0};
        tbl[2] = '{-1000, 0, 0, 5, 0, -8000, 140, 0};
        tbl[3] = '{-32768, 0, 32767, 0, 1, -262144, 262136, 0};
        tbl[4] = '{10, -3, -7, 2, 0, -4, 0, 0};

        rst = 1'b1;
        d_in_valid = 1'b0; d_in_real = '0; d_in_imag = '0; d_out_ready = 1'b1;
        o_in_valid = 1'b0; o_in_real = '0; o_in_imag = '0; o_out_ready = 1'b1;
        l_in_valid = 1'b0; l_in_real = '0; l_in_imag = '0; l_out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", longint'(d_in_ready), 1);
        check("rst_out_valid", longint'(d_out_valid), 0);
        check("rst_term_cnt", longint'(d_term_cnt), 0);
        check("rst_out_real", longint'(d_out_real), 0);
        check("rst_out_ovf", longint'(d_out_ovf), 0);
        rst = 1'b0;
        @(negedge CLK);

        // Lane overflow and sticky-flag clear on the ACC_W=16, LEN=2 DUT.
        o_vec(32767, 1, OVF_POS_EXP, 1);
        o_vec(1, 2, 3, 0);
        o_vec(-32768, -1, OVF_NEG_EXP, 1);

        // LEN=1: every sample is its own result.
        l_one(-5, 7);
        l_one(3, -2);
        @(negedge CLK);

        // Table-driven vectors on the default DUT.
        for (int v = 0; v < 5; v++) begin
            sb_q.push_back('{tbl[v].exp_re, tbl[v].exp_im, tbl[v].exp_ovf});
            for (int k = 0; k < 8; k++) begin
                send(tbl[v].re0 + k * tbl[v].re_step, tbl[v].im0 + k * tbl[v].im_step);
                check("term_cnt", longint'(d_term_cnt), k + 1);
                check("latency", longint'(d_out_valid), (k == 7) ? 1 : 0);
                if (tbl[v].gap != 0 && k < 7) begin
                    d_in_valid = 1'b0;
                    @(negedge CLK);
                    check("gap_cnt", longint'(d_term_cnt), k + 1);
                end
            end
        end
        d_in_valid = 1'b0;
        @(negedge CLK);

        // Stall the result for 20 cycles with the source still pushing.
        d_out_ready = 1'b0;
        sb_q.push_back('{24, 32, 0});
        for (int k = 0; k < 8; k++) begin
            send(3, 4);
        end
        d_in_real = 16'(7);
        d_in_imag = 16'(9);
        for (int i = 0; i < 20; i++) begin
            check("hold_in_ready", longint'(d_in_ready), 0);
            check("hold_valid", longint'(d_out_valid), 1);
            check("hold_real", longint'($signed(d_out_real)), 24);
            check("hold_imag", longint'($signed(d_out_imag)), 32);
            @(negedge CLK);
        end
        d_out_ready = 1'b1;
        sb_q.push_back('{56, 72, 0});
        for (int k = 0; k < 8; k++) begin
            send(7, 9);
        end
        d_in_valid = 1'b0;
        @(negedge CLK);

        // Abort a vector with reset; only the following vector reports.
        for (int k = 0; k < 5; k++) begin
            send(50, 50);
        end
        d_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge CLK);
        check("abort_valid", longint'(d_out_valid), 0);
        check("abort_in_ready", longint'(d_in_ready), 1);
        check("abort_real", longint'(d_out_real), 0);
        check("abort_imag", longint'(d_out_imag), 0);
        check("abort_ovf", longint'(d_out_ovf), 0);
        check("abort_cnt", longint'(d_term_cnt), 0);
        rst = 1'b0;
        sb_q.push_back('{16, 24, 0});
        for (int k = 0; k < 8; k++) begin
            send(2, 3);
        end
        d_in_valid = 1'b0;

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) begin
            @(negedge CLK);
        end
        @(negedge CLK);
        check("sb_empty", longint'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/complex_accumulator.md
Name: complex_accumulator

Overview:
Parametrised successor to the two-lane complex adder. It sums LEN consecutive complex samples (real/imag, two's-complement fixed point) into a widened accumulator and emits one complex result per vector. It is the reduction stage of the VMM datapath, sitting after the complex multipliers, with valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, input real/imag width (two's complement)
ACC_W, 24, accumulator/output width; must be >= DATA_W
LEN, 8, complex terms per vector; must be >= 1
CNT_W, $clog2(LEN+1), term counter width (derived; not overridden)

Ports:
CLK  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  accumulator accepts sample
in_real  in  DATA_W  input real part
in_imag  in  DATA_W  input imag part
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_real  out  ACC_W  accumulated real sum
out_imag  out  ACC_W  accumulated imag sum
out_ovf  out  1  overflow occurred in this vector (either lane)
term_cnt  out  CNT_W  terms accepted in current vector

Behaviour:
- One clock (CLK). Reset rst is synchronous and active-high.
- Reset, sampled on a rising edge: state=ACCUM, accumulators=0, term_cnt=0, out_valid=0, out_ovf=0, out_real=0, out_imag=0. in_ready=1 from the first cycle after reset.
- Reset mid-vector or while a result is held: the partial sum or held result is discarded with no output.
- State ACCUM: in_ready=1, out_valid=0.
  - Transfer when in_valid&in_ready. Each lane computes acc + sign_extend(in, ACC_W) at ACC_W+1 bits.
  - Lane overflow: the two MSBs of the ACC_W+1 sum differ.
  - term_cnt increments on each transfer.
  - On the transfer that makes term_cnt reach LEN:
    - the final sums load into out_real/out_imag;
    - out_ovf = sticky flag OR this cycle's overflow;
    - out_valid=1 next cycle; state -> HOLD.
- State HOLD: in_ready=0; out_real, out_imag and out_ovf stay stable.
  - On out_valid&out_ready: out_valid=0 next cycle, accumulators/term_cnt/sticky flag clear, state -> ACCUM.
- Latency: result valid exactly 1 cycle after the LEN-th accepted sample.
- Throughput: LEN+1 cycles per vector at best, since one cycle is spent in HOLD.
- in_valid gaps are allowed anywhere and do not affect the sum.
- out_ready held low stalls indefinitely with no data loss.
- LEN=1: every accepted sample produces a result (sign-extended input).
- Sticky overflow flag: set on any lane overflow during the vector; cleared only on handshake or reset.
- Overflow handling without the optional feature: the accumulator wraps modulo 2^ACC_W.

Optional Feature:
COMPLEX_ACC_SAT_EN
- Defined:
  - On lane overflow, that lane's accumulator saturates to +(2^(ACC_W-1)-1) if the true sum is positive, or -2^(ACC_W-1) if negative.
  - Later terms continue from the saturated value.
  - out_ovf is still reported.
- Undefined: wrap-around arithmetic; out_ovf still reported. No port or latency difference.

Test Plan:
- Defaults; LEN=8 back-to-back samples real=1..8, imag=-1..-8, out_ready=1 -> out_real=36, out_imag=-36, out_ovf=0; out_valid rises 1 cycle after the 8th transfer; the next vector starts from 0.
- in_valid toggled 1010..., 8 samples of (100,-100) -> (800,-800); term_cnt steps only on transfers.
- Result held with out_ready=0 for 20 cycles while in_valid=1 -> in_ready=0 throughout, out_* stable, no samples lost; first sample after the handshake counts toward the next vector.
- ACC_W=16, DATA_W=16, LEN=2, real samples 32767 and 1 -> out_ovf=1.
  - Without macro: out_real=-32768.
  - With COMPLEX_ACC_SAT_EN: out_real=32767.
  - The imag lane (0,0) stays 0.
- rst asserted after 5 of 8 samples, then 8 samples of (2,3) -> single result (16,24); no output from the aborted vector; all outputs 0 the cycle after rst.
- LEN=1, samples (-5,7),(3,-2) with out_ready=1 -> results (-5,7) then (3,-2), each 1 cycle after its transfer.
